// File: rtl/equiv_pkg.sv
// Shared types and helpers for the exhaustive equivalence stimulus generator.
// Holds the sweep state encoding, the settle-timer width and vector-range helpers.
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int TIMER_W  = 4;
  localparam int N_IN_MAX = 8;

  // Number of vectors in a full sweep of n_in inputs.
  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // All-ones vector for n_in inputs, zero-extended to the widest legal sweep.
  function automatic logic [N_IN_MAX-1:0] last_vec(input int unsigned n_in);
    return N_IN_MAX'((32'd1 << n_in) - 32'd1);
  endfunction

endpackage

// File: rtl/exhaustive_equiv_stim_settle_timer.sv
// Loadable down-counter used to hold each stimulus vector for the settle time.
// Decrement saturates at zero; zero_o flags that the wait has elapsed.
module settle_timer
  import equiv_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exhaustive_equiv_stim.sv
// Sweeps every input vector in ascending order into a reference and a candidate
// circuit, waits a settle time, compares their outputs and accumulates mismatches.
module exhaustive_equiv_stim
  import equiv_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            q_ref,
  input  logic            q_dut,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int unsigned          N_VEC     = n_vec(N_IN);
  localparam int                   MM_W      = $clog2(N_VEC) + 1;
  localparam logic [N_IN_MAX-1:0]  LAST_FULL = last_vec(N_IN);
  localparam logic [N_IN-1:0]      LAST      = LAST_FULL[N_IN-1:0];
  localparam logic [TIMER_W-1:0]   SETTLE_V  = TIMER_W'(SETTLE);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [MM_W-1:0]   mm_q, mm_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffvalid_q, ffvalid_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              mismatch;

  settle_timer #(.W(TIMER_W)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_V),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign mismatch = (q_ref != q_dut);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    mm_d      = mm_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // start beats a simultaneous abort here; abort alone is a no-op.
        if (start) begin
          state_d   = WAIT;
          vec_d     = '0;
          mm_d      = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            mm_d = mm_q + MM_W'(1);
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == LAST) begin
            state_d = DONE;
            pass_d  = (mm_d == '0);
          end else begin
            state_d  = WAIT;
            vec_d    = vec_q + N_IN'(1);
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      mm_q      <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      mm_q      <= mm_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
